// File: rtl/psum_writeback.sv
// psum_writeback: per-row psum capture FIFOs drained round-robin onto one BRAM write port.
// Build option PSUM_RELU_EN clamps negative write data to zero as the output register loads.

module psum_wb_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Caller guarantees push only when not full (or popping) and pop only when not empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

module psum_writeback #(
  parameter int ARRAY_ROWS = 3,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_STRIDE = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [ADDR_W-1:0]                   base_addr,
  input  logic [ARRAY_ROWS-1:0]               psum_valid,
  input  logic [ARRAY_ROWS-1:0][ADDR_W-1:0]   psum_addr,
  input  logic [ARRAY_ROWS-1:0][DATA_W-1:0]   psum_data,
  input  logic                                ctrl_done,
  input  logic                                mem_ready,
  output logic                                mem_we,
  output logic [ADDR_W-1:0]                   mem_waddr,
  output logic [DATA_W-1:0]                   mem_wdata,
  output logic                                busy,
  output logic                                overflow,
  output logic                                wb_done
);
  localparam int RW = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;
  localparam int EW = ADDR_W + DATA_W;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_W-1:0]       base_q;
  logic [RW-1:0]           last_grant;
  logic [RW-1:0]           grant;
  logic [RW-1:0]           cand;
  logic                    found;
  logic                    load;
  logic [ARRAY_ROWS-1:0]   accept;
  logic [ARRAY_ROWS-1:0]   push;
  logic [ARRAY_ROWS-1:0]   pop;
  logic [ARRAY_ROWS-1:0]   drop;
  logic [ARRAY_ROWS-1:0]   empty;
  logic [ARRAY_ROWS-1:0]   full;
  logic [EW-1:0]           fifo_wdata [ARRAY_ROWS];
  logic [EW-1:0]           fifo_rdata [ARRAY_ROWS];
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_raw;
  logic [DATA_W-1:0]       sel_data;

  // Output register can take a new entry when empty or when its current write is accepted.
  assign load = !mem_we || mem_ready;

  for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_row
    assign accept[r]     = (state == COLLECT) && psum_valid[r];
    assign push[r]       = accept[r] && (!full[r] || pop[r]);
    assign drop[r]       = accept[r] && full[r] && !pop[r];
    assign fifo_wdata[r] = {base_q + ADDR_W'(r * ROW_STRIDE) + psum_addr[r], psum_data[r]};

    psum_wb_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[r]),
      .pop   (pop[r]),
      .wdata (fifo_wdata[r]),
      .rdata (fifo_rdata[r]),
      .empty (empty[r]),
      .full  (full[r])
    );
  end

  // Round-robin: first non-empty row after the last one granted.
  always_comb begin
    found = 1'b0;
    grant = last_grant;
    cand  = '0;
    pop   = '0;
    for (int i = 1; i <= ARRAY_ROWS; i++) begin
      cand = RW'((int'(last_grant) + i) % ARRAY_ROWS);
      if (!found && !empty[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
    if (load && found) pop[grant] = 1'b1;
  end

  assign {sel_addr, sel_raw} = fifo_rdata[grant];
`ifdef PSUM_RELU_EN
  assign sel_data = sel_raw[DATA_W-1] ? '0 : sel_raw;
`else
  assign sel_data = sel_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      last_grant <= '0;
    end else if (load) begin
      mem_we <= found;
      if (found) begin
        mem_waddr  <= sel_addr;
        mem_wdata  <= sel_data;
        last_grant <= grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_q   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        base_q   <= base_addr;
        overflow <= 1'b0;
      end else if (|drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    wb_done   = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: begin
        busy = 1'b1;
        if (ctrl_done) state_nxt = DRAIN;
      end
      DRAIN:   begin
        busy = 1'b1;
        if (&empty && load) state_nxt = DONE;
      end
      DONE:    begin
        wb_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_psum_writeback.sv
// Bench for psum_writeback: queue-based reference model compared every cycle, plus directed literal checks.
module tb_psum_writeback;
  localparam int ROWS   = 3;
  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int DEPTH  = 4;
  localparam int STRIDE = 3;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      start = 1'b0;
  logic                      ctrl_done = 1'b0;
  logic                      mem_ready;
  logic [AW-1:0]             base_addr = '0;
  logic [ROWS-1:0]           psum_valid = '0;
  logic [ROWS-1:0][AW-1:0]   psum_addr = '0;
  logic [ROWS-1:0][DW-1:0]   psum_data = '0;
  logic                      mem_we;
  logic [AW-1:0]             mem_waddr;
  logic [DW-1:0]             mem_wdata;
  logic                      busy;
  logic                      overflow;
  logic                      wb_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  int rcyc = 0;
  logic [63:0] wlog [$];

  psum_writeback #(
    .ARRAY_ROWS (ROWS),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH),
    .ROW_STRIDE (STRIDE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .psum_valid (psum_valid),
    .psum_addr  (psum_addr),
    .psum_data  (psum_data),
    .ctrl_done  (ctrl_done),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .overflow   (overflow),
    .wb_done    (wb_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] d);
`ifdef PSUM_RELU_EN
    return d[31] ? 32'h0 : d;
`else
    return d;
`endif
  endfunction

  // ready pattern generator
  always @(negedge clk) begin
    rcyc++;
    case (rdy_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = (rcyc % 3 == 0);
      2:       mem_ready = 1'($urandom_range(0, 1));
      default: mem_ready = 1'b0;
    endcase
  end

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_COLLECT = 1, P_DRAIN = 2, P_DONE = 3;
  int          m_phase = P_IDLE;
  int          nphase;
  int          m_last = 0;
  int          rr;
  logic [63:0] q [ROWS][$];
  logic [63:0] ent;
  logic        m_we = 1'b0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_base = '0;
  bit          all_empty;
  bit          can_load;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE;
      for (int r = 0; r < ROWS; r++) q[r].delete();
      m_we = 0; m_ovf = 0; m_addr = 0; m_data = 0; m_base = 0; m_last = 0;
    end else begin
      all_empty = 1;
      for (int r = 0; r < ROWS; r++) if (q[r].size() != 0) all_empty = 0;
      can_load = !m_we || mem_ready;
      nphase = m_phase;
      case (m_phase)
        P_IDLE:    if (start) begin nphase = P_COLLECT; m_base = base_addr; m_ovf = 0; end
        P_COLLECT: if (ctrl_done) nphase = P_DRAIN;
        P_DRAIN:   if (all_empty && can_load) nphase = P_DONE;
        default:   nphase = P_IDLE;
      endcase
      if (can_load) begin
        m_we = 0;
        for (int i = 1; i <= ROWS; i++) begin
          rr = (m_last + i) % ROWS;
          if (!m_we && q[rr].size() > 0) begin
            ent    = q[rr].pop_front();
            m_we   = 1;
            m_addr = ent[63:32];
            m_data = relu(ent[31:0]);
            m_last = rr;
          end
        end
      end
      if (m_phase == P_COLLECT) begin
        for (int r = 0; r < ROWS; r++) begin
          if (psum_valid[r]) begin
            if (q[r].size() < DEPTH)
              q[r].push_back({32'(m_base + 32'(r * STRIDE) + psum_addr[r]), psum_data[r]});
            else
              m_ovf = 1;
          end
        end
      end
      m_phase = nphase;
    end
  end

  always @(posedge clk) begin
    if (rst_n && mem_we && mem_ready) wlog.push_back({mem_waddr, mem_wdata});
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("mem_we", mem_we, m_we);
      if (m_we) begin
        chk("mem_waddr", mem_waddr, m_addr);
        chk("mem_wdata", mem_wdata, m_data);
      end
      chk("busy", busy, (m_phase == P_COLLECT || m_phase == P_DRAIN));
      chk("overflow", overflow, m_ovf);
      chk("wb_done", wb_done, (m_phase == P_DONE));
      if (wb_done) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_in();
    psum_valid = '0; start = 0; ctrl_done = 0;
  endtask

  task automatic pulse_start(input logic [31:0] b);
    base_addr = b; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (wb_done) seen = 1;
    end
    chk("wb_done_seen", seen, 1);
  endtask

  task automatic skewed_pass(input logic [31:0] b, input int mode);
    rdy_mode = mode;
    pulse_start(b);
    for (int c = 1; c <= 8; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        psum_valid[r] = (c >= 3 + r) && (c < 6 + r);
        psum_addr[r]  = 32'(c - 3 - r);
        psum_data[r]  = $urandom;
      end
      ctrl_done = (c == 8);
      @(negedge clk);
    end
    clear_in();
  endtask

  initial begin
    int n0;
    int d0;
    int k;
    int len;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_wb_done", wb_done, 0);
    rst_n = 1;
    @(negedge clk);

    // basic skewed 3x3
    n0 = wlog.size(); d0 = done_cnt;
    skewed_pass(32'h100, 0);
    wait_done(100);
    chk("basic_writes", wlog.size() - n0, 9);
    k = 0;
    for (int i = n0; i < wlog.size(); i++) begin
      a = wlog[i][63:32];
      if (a >= 32'h103 && a <= 32'h105) begin
        chk("basic_row1_addr", a, 32'h103 + k);
        k++;
      end
    end
    chk("basic_row1_count", k, 3);
    repeat (2) @(negedge clk);
    chk("basic_done_pulses", done_cnt - d0, 1);
    chk("basic_busy_after", busy, 0);
    chk("basic_overflow", overflow, 0);

    // backpressure 1,0,0 pattern
    n0 = wlog.size();
    skewed_pass(32'h40, 1);
    wait_done(200);
    chk("bp_writes_at_done", wlog.size() - n0, 9);
    rdy_mode = 0;

    // overflow on row 0
    rdy_mode = 3;
    @(negedge clk);
    n0 = wlog.size();
    pulse_start(32'h0);
    for (int i = 1; i <= 6; i++) begin
      psum_valid = 3'b001; psum_addr[0] = 32'(i - 1); psum_data[0] = 32'(i);
      @(negedge clk);
    end
    clear_in();
    @(negedge clk);
    chk("ovf_set", overflow, 1);
    ctrl_done = 1;
    @(negedge clk);
    ctrl_done = 0; rdy_mode = 0;
    wait_done(100);
    chk("ovf_writes", wlog.size() - n0, 5);
    for (int i = 0; i < 5 && n0 + i < wlog.size(); i++) chk("ovf_data", wlog[n0 + i][31:0], 32'(i + 1));
    chk("ovf_sticky", overflow, 1);

    // round-robin after a row-0 grant
    @(negedge clk);
    pulse_start(32'h0);
    chk("ovf_cleared", overflow, 0);
    psum_valid = 3'b001; psum_data[0] = 32'h1; psum_addr[0] = 0;
    @(negedge clk);
    clear_in();
    repeat (4) @(negedge clk);
    n0 = wlog.size();
    psum_valid = 3'b111;
    psum_addr[0] = 0; psum_addr[1] = 0; psum_addr[2] = 0;
    psum_data[0] = 32'hA; psum_data[1] = 32'hB; psum_data[2] = 32'hC;
    @(negedge clk);
    clear_in(); ctrl_done = 1;
    @(negedge clk);
    ctrl_done = 0;
    wait_done(100);
    chk("rr_writes", wlog.size() - n0, 3);
    if (wlog.size() >= n0 + 3) begin
      chk("rr_first", wlog[n0][31:0], 32'hB);
      chk("rr_second", wlog[n0 + 1][31:0], 32'hC);
      chk("rr_third", wlog[n0 + 2][31:0], 32'hA);
      chk("rr_row2_addr", wlog[n0 + 1][63:32], 32'h6);
    end

    // start while busy ignored; ctrl_done with the final psum
    @(negedge clk);
    n0 = wlog.size();
    pulse_start(32'h200);
    start = 1; base_addr = 32'h900;
    psum_valid = 3'b100; psum_addr[2] = 5; psum_data[2] = 32'h55; ctrl_done = 1;
    @(negedge clk);
    clear_in();
    wait_done(100);
    chk("edge_writes", wlog.size() - n0, 1);
    if (wlog.size() > n0) chk("edge_entry", wlog[n0], {32'h20B, 32'h55});

    // reset in the middle of DRAIN
    rdy_mode = 3;
    @(negedge clk);
    pulse_start(32'h0);
    for (int i = 0; i < 6; i++) begin
      psum_valid = 3'b011; psum_data[0] = $urandom; psum_data[1] = $urandom;
      @(negedge clk);
    end
    clear_in(); ctrl_done = 1;
    @(negedge clk);
    ctrl_done = 0;
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1; rdy_mode = 0;
    n0 = wlog.size();
    repeat (6) @(negedge clk);
    chk("mid_rst_fifo_flushed", wlog.size() - n0, 0);

    // ReLU behaviour
    n0 = wlog.size();
    pulse_start(32'h0);
    psum_valid = 3'b001; psum_addr[0] = 0; psum_data[0] = 32'hFFFF_FFF6;
    @(negedge clk);
    psum_addr[0] = 1; psum_data[0] = 32'h7;
    @(negedge clk);
    clear_in(); ctrl_done = 1;
    @(negedge clk);
    ctrl_done = 0;
    wait_done(100);
    chk("relu_writes", wlog.size() - n0, 2);
    if (wlog.size() >= n0 + 2) begin
`ifdef PSUM_RELU_EN
      chk("relu_neg", wlog[n0][31:0], 32'h0);
`else
      chk("relu_neg", wlog[n0][31:0], 32'hFFFF_FFF6);
`endif
      chk("relu_pos", wlog[n0 + 1][31:0], 32'h7);
    end

    // randomized passes
    for (int p = 0; p < 25; p++) begin
      rdy_mode = 2;
      pulse_start($urandom);
      len = $urandom_range(3, 40);
      for (int c = 0; c < len; c++) begin
        psum_valid = ROWS'($urandom);
        for (int r = 0; r < ROWS; r++) begin
          psum_addr[r] = $urandom_range(0, 15);
          psum_data[r] = $urandom;
        end
        start     = ($urandom_range(0, 7) == 0);
        base_addr = $urandom;
        ctrl_done = (c == len - 1);
        @(negedge clk);
      end
      clear_in();
      wait_done(500);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end
endmodule
